// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: shared execution-unit encoding, CDB slot type and default latencies
package issue_unit_pkg;
  typedef enum logic [1:0] {
    EU_INT   = 2'd0,
    EU_LD_ST = 2'd1,
    EU_MULT  = 2'd2,
    EU_DIV   = 2'd3
  } exec_unit_e;
  typedef struct packed {
    logic       valid;
    exec_unit_e unit;
  } cdb_slot_t;
  localparam int INT_LAT_DEF   = 1;
  localparam int LD_ST_LAT_DEF = 2;
  localparam int MULT_LAT_DEF  = 4;
  localparam int DIV_LAT_DEF   = 8;
endpackage

// File: rtl/issue_unit_if.sv
// issue_unit_if: reservation-station ready/pop handshakes and CDB source select
interface issue_unit_if;
  import issue_unit_pkg::*;
  logic       flush;
  logic       int_rdy, ld_st_rdy, mult_rdy, div_rdy;
  logic       int_rd, ld_st_rd, mult_rd, div_rd;
  exec_unit_e cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;
  modport master (
    output flush, int_rdy, ld_st_rdy, mult_rdy, div_rdy,
    input  int_rd, ld_st_rd, mult_rd, div_rd, cdb_sel, cdb_sel_valid, div_busy
  );
  modport slave (
    input  flush, int_rdy, ld_st_rdy, mult_rdy, div_rdy,
    output int_rd, ld_st_rd, mult_rd, div_rd, cdb_sel, cdb_sel_valid, div_busy
  );
endinterface

// File: rtl/issue_unit_rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter, search starts one past the last grant
module rr_arbiter_4 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt
);
  logic [1:0] last_grant_q, last_grant_d, idx;
  always_comb begin
    o_gnt = '0;
    last_grant_d = last_grant_q;
    idx = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last_grant_q + 2'(i);
      if (i_req[idx]) begin
        o_gnt = 4'b0001 << idx;
        last_grant_d = idx;
      end
    end
  end
  always_ff @(posedge i_clk)
    last_grant_q <= i_rst ? 2'd3 : last_grant_d;
endmodule

// File: rtl/issue_unit.sv
// issue_unit: grants one ready reservation-station head per cycle into a free CDB slot
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT   = INT_LAT_DEF,
  parameter int LD_ST_LAT = LD_ST_LAT_DEF,
  parameter int MULT_LAT  = MULT_LAT_DEF,
  parameter int DIV_LAT   = DIV_LAT_DEF
) (
  input logic         i_clk,
  input logic         i_rst,
  issue_unit_if.slave bus
);
  cdb_slot_t [DIV_LAT-1:0] res_q, res_d;
  logic [3:0] div_cnt_q, div_cnt_d;
  logic [3:0] req, gnt;
  logic       go;
  assign go = !bus.flush && !i_rst;
  assign req = {bus.div_rdy && div_cnt_q == '0,
                bus.mult_rdy && !res_q[MULT_LAT].valid,
                bus.ld_st_rdy && !res_q[LD_ST_LAT].valid,
                bus.int_rdy && !res_q[INT_LAT].valid} & {4{go}};
  rr_arbiter_4 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (req),
    .o_gnt (gnt)
  );
  always_comb begin
    res_d = bus.flush ? '0 : {cdb_slot_t'('0), res_q[DIV_LAT-1:1]};
    if (gnt[0]) res_d[INT_LAT-1] = '{valid: 1'b1, unit: EU_INT};
    if (gnt[1]) res_d[LD_ST_LAT-1] = '{valid: 1'b1, unit: EU_LD_ST};
    if (gnt[2]) res_d[MULT_LAT-1] = '{valid: 1'b1, unit: EU_MULT};
    if (gnt[3]) res_d[DIV_LAT-1] = '{valid: 1'b1, unit: EU_DIV};
    div_cnt_d = bus.flush ? '0 : gnt[3] ? 4'(DIV_LAT - 1) : (div_cnt_q != '0) ? div_cnt_q - 4'd1 : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_q <= '0;
      div_cnt_q <= '0;
    end else begin
      res_q <= res_d;
      div_cnt_q <= div_cnt_d;
    end
  end
  assign bus.int_rd = gnt[0];
  assign bus.ld_st_rd = gnt[1];
  assign bus.mult_rd = gnt[2];
  assign bus.div_rd = gnt[3];
  assign bus.cdb_sel_valid = res_q[0].valid;
  assign bus.cdb_sel = res_q[0].unit;
  assign bus.div_busy = div_cnt_q != '0;
endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: random and directed stimulus against a cycle-indexed CDB schedule model
module tb_issue_unit;
  import issue_unit_pkg::*;
  localparam int LAT [4] = '{1, 2, 4, 8};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_mis = 0;
  int now = 0, last = 3, div_start = 0, div_free = 0;
  int sched [int];
  issue_unit_if bus();
  issue_unit #(.INT_LAT(1), .LD_ST_LAT(2), .MULT_LAT(4), .DIV_LAT(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0h want %0h", tag, now, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] rdy, input logic fl, input logic rs);
    logic [3:0] exp_rd = '0;
    logic busy;
    int g = -1;
    {bus.div_rdy, bus.mult_rdy, bus.ld_st_rdy, bus.int_rdy} = rdy;
    bus.flush = fl;
    rst = rs;
    #2;
    busy = now > div_start && now < div_free;
    for (int i = 1; i <= 4; i++) begin
      int u = (last + i) % 4;
      if (g < 0 && rdy[u] && !fl && !rs && !sched.exists(now + LAT[u]) && (u != 3 || !busy)) g = u;
    end
    if (g >= 0) exp_rd[g] = 1'b1;
    chk("rd", {bus.div_rd, bus.mult_rd, bus.ld_st_rd, bus.int_rd}, exp_rd);
    chk("cdb_valid", bus.cdb_sel_valid, sched.exists(now));
    if (sched.exists(now)) chk("cdb_sel", bus.cdb_sel, sched[now]);
    chk("div_busy", bus.div_busy, busy);
    sched.delete(now);
    if (g >= 0) begin
      sched[now + LAT[g]] = g;
      last = g;
      if (g == 3) begin
        div_start = now;
        div_free = now + 8;
      end
    end
    if (fl || rs) begin
      sched.delete();
      div_start = 0;
      div_free = 0;
      if (rs) last = 3;
    end
    @(posedge clk);
    #1;
    now++;
  endtask
  initial begin
    bus.flush = 1'b0;
    {bus.div_rdy, bus.mult_rdy, bus.ld_st_rdy, bus.int_rdy} = 4'hF;
    @(posedge clk);
    #1;
    chk("rst_sel", bus.cdb_sel, EU_INT);
    chk("rst_valid", bus.cdb_sel_valid, 0);
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b1);
    repeat (8) step(4'h1, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    step(4'h4, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0);
    step(4'h2, 1'b0, 1'b0);
    repeat (4) step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    repeat (20) step(4'h8, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    repeat (24) step(4'hF, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b1);
    step(4'h4, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    step(4'h4, 1'b1, 1'b0);
    repeat (6) step(4'h4, 1'b0, 1'b0);
    repeat (3000) step(4'($urandom), $urandom_range(19) == 0, $urandom_range(99) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
